// File: rtl/jtag_tap_sequencer.sv
// jtag_tap_sequencer: JTAG master that runs IR/DR scans and TAP resets from the system clock,
// generating TCK/TMS/TDI and returning the captured TDO bits.
module jtag_tap_sequencer #(
  parameter int DATA_W  = 64,
  parameter int LEN_W   = 7,
  parameter int CLK_DIV = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_ir,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_busy,
  output logic              o_jtag_tck,
  output logic              o_jtag_tms,
  output logic              o_jtag_tdi,
  input  logic              i_jtag_tdo
);
  localparam int CW = $clog2(2 * CLK_DIV) + 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] C_RISE = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_FALL = CW'(2 * CLK_DIV - 1);
  typedef enum logic [2:0] {RST_SEQ, IDLE, HDR, SHIFT, TRAIL, RSP} state_t;
  state_t            r_state, w_ns;
  logic [CW-1:0]     r_cnt;
  logic [LEN_W-1:0]  r_idx, r_len, w_ni, w_last;
  logic              r_ir, r_start, r_cmd, w_tms, w_tdi;
  logic [DATA_W-1:0] r_data;
  // Next TCK cycle: r_start replays index 0 of the current state instead of advancing.
  always_comb begin
    w_last = r_state == RST_SEQ ? LEN_W'(5) :
             r_state == HDR     ? (r_ir ? LEN_W'(3) : LEN_W'(2)) :
             r_state == TRAIL   ? LEN_W'(1) : r_len - 1'b1;
    w_ns   = (r_start || r_idx != w_last) ? r_state :
             r_state == RST_SEQ ? (r_cmd ? RSP : IDLE) :
             r_state == HDR     ? SHIFT :
             r_state == SHIFT   ? TRAIL : RSP;
    w_ni   = (r_start || r_idx == w_last) ? '0 : r_idx + 1'b1;
    w_tms  = w_ns == RST_SEQ ? (w_ni < LEN_W'(5)) :
             w_ns == HDR     ? (w_ni == '0 || (r_ir && w_ni == LEN_W'(1))) :
             w_ns == SHIFT   ? (w_ni == r_len - 1'b1) :
             w_ns == TRAIL   ? (w_ni == '0) : 1'b0;
    w_tdi  = w_ns == SHIFT && r_data[w_ni[IW-1:0]];
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= RST_SEQ;
      r_cnt       <= C_FALL;
      r_start     <= 1'b1;
      r_cmd       <= 1'b0;
      r_idx       <= '0;
      r_ir        <= 1'b0;
      r_len       <= '0;
      r_data      <= '0;
      o_jtag_tck  <= 1'b0;
      o_jtag_tms  <= 1'b1;
      o_jtag_tdi  <= 1'b0;
      o_cmd_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_busy      <= 1'b1;
    end else if (r_state == IDLE) begin
      if (i_cmd_valid) begin
        r_ir        <= i_cmd_ir;
        r_len       <= i_cmd_len > LEN_W'(DATA_W) ? LEN_W'(DATA_W) : i_cmd_len;
        r_data      <= i_cmd_data;
        r_state     <= i_cmd_len == '0 ? RST_SEQ : HDR;
        r_cmd       <= 1'b1;
        r_start     <= 1'b1;
        r_cnt       <= C_FALL;
        r_idx       <= '0;
        o_rsp_data  <= '0;
        o_cmd_ready <= 1'b0;
        o_busy      <= 1'b1;
      end
    end else if (r_state == RSP) begin
      if (i_rsp_ready) begin
        r_state     <= IDLE;
        o_rsp_valid <= 1'b0;
        o_cmd_ready <= 1'b1;
        o_busy      <= 1'b0;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == C_RISE) begin
        o_jtag_tck <= 1'b1;
        if (r_state == SHIFT) o_rsp_data[r_idx[IW-1:0]] <= i_jtag_tdo;
      end
      if (r_cnt == C_FALL) begin
        r_cnt       <= '0;
        r_start     <= 1'b0;
        r_state     <= w_ns;
        r_idx       <= w_ni;
        o_jtag_tck  <= 1'b0;
        o_jtag_tms  <= w_tms;
        o_jtag_tdi  <= w_tdi;
        o_rsp_valid <= w_ns == RSP;
        o_cmd_ready <= w_ns == IDLE;
        o_busy      <= w_ns != IDLE;
      end
    end
  end
endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// tb_jtag_tap_sequencer: directed bench with a behavioural TAP (8-bit DR, 5-bit IR) and a
// response scoreboard.
module tb_jtag_tap_sequencer;
  localparam int DW = 64, LW = 7, CD = 2;
  localparam logic [7:0] DR_CAP = 8'h3C;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_ir = 0, rsp_ready = 0;
  logic cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_data = '0, rsp_data, d;
  int errors = 0, checks = 0, n_rise = 0;
  logic q_tms[$], q_tdi[$];
  logic [63:0] sb[$];
  always #5 clk = ~clk;
  jtag_tap_sequencer #(.DATA_W(DW), .LEN_W(LW), .CLK_DIV(CD)) dut (
    .i_clock(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_ir(cmd_ir), .i_cmd_len(cmd_len), .i_cmd_data(cmd_data), .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data), .o_busy(busy), .o_jtag_tck(tck),
    .o_jtag_tms(tms), .o_jtag_tdi(tdi), .i_jtag_tdo(tdo)
  );
  typedef enum logic [3:0] {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                            SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
  tap_t ts = TLR;
  logic [7:0] dr_sr = '0;
  logic [4:0] ir_sr = '0, ir = 5'h01;
  function automatic tap_t nxt(tap_t s, logic m);
    case (s)
      TLR:       return m ? TLR  : RTI;
      RTI:       return m ? SDR  : RTI;
      SDR:       return m ? SIR  : CDR;
      CDR, SHDR: return m ? E1DR : SHDR;
      E1DR:      return m ? UDR  : PDR;
      PDR:       return m ? E2DR : PDR;
      E2DR:      return m ? UDR  : SHDR;
      UDR, UIR:  return m ? SDR  : RTI;
      SIR:       return m ? TLR  : CIR;
      CIR, SHIR: return m ? E1IR : SHIR;
      E1IR:      return m ? UIR  : PIR;
      PIR:       return m ? E2IR : PIR;
      default:   return m ? UIR  : SHIR;
    endcase
  endfunction
  assign tdo = ts == SHDR ? dr_sr[0] : ts == SHIR ? ir_sr[0] : 1'b0;
  always @(posedge tck) begin
    q_tms.push_back(tms);
    q_tdi.push_back(tdi);
    n_rise++;
    case (ts)
      CDR:     dr_sr <= DR_CAP;
      SHDR:    dr_sr <= {tdi, dr_sr[7:1]};
      CIR:     ir_sr <= 5'h01;
      SHIR:    ir_sr <= {tdi, ir_sr[4:1]};
      UIR:     ir <= ir_sr;
      TLR:     ir <= 5'h01;
      default: ;
    endcase
    ts <= nxt(ts, tms);
  end
  task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // TMS values in order, first TCK cycle in the MSB.
  function automatic logic [63:0] tms_seq(int from, int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], q_tms[from+i]};
    return v;
  endfunction
  function automatic logic [63:0] tdi_seq(int from, int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = q_tdi[from+i];
    return v;
  endfunction
  task automatic send(input logic ir_i, input logic [LW-1:0] len, input logic [63:0] data,
                      output int mark);
    int k = 0;
    while (!cmd_ready && k < 1000) begin tick(); k++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1; cmd_ir = ir_i; cmd_len = len; cmd_data = data;
    @(posedge clk);
    mark = q_tms.size();
    #1;
    cmd_valid = 0;
    chk("accepted", {busy, cmd_ready}, 2'b10);
  endtask
  task automatic wait_rsp(string tag, int lat);
    int k = 0;
    do begin tick(); k++; end while (!rsp_valid && k < 2000);
    chk({tag, "_latency"}, k, lat);
    chk({tag, "_sb"}, sb.size() > 0, 1);
    if (rsp_valid && sb.size() > 0) chk({tag, "_data"}, rsp_data, sb.pop_front());
  endtask
  task automatic release_rsp(string tag);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk({tag, "_release"}, {rsp_valid, cmd_ready, busy}, 3'b010);
  endtask
  initial begin
    int m, k, n0, stale;
    tick(3);
    chk("reset_ctl", {tck, tms, tdi, cmd_ready, rsp_valid, busy}, 6'b010001);
    chk("reset_data", rsp_data, 0);
    m = q_tms.size();
    rst = 0;
    k = 0;
    while (!cmd_ready && k < 200) begin tick(); k++; end
    chk("por_latency", k, 25);
    chk("por_tck_count", q_tms.size() - m, 6);
    chk("por_tms", tms_seq(m, 6), 64'h3E);
    chk("por_tap_rti", ts, RTI);
    // DR scan, then hold the response under backpressure
    send(0, 8, 64'hA5, m);
    sb.push_back(64'h3C);
    wait_rsp("dr", 53);
    chk("dr_tck_count", q_tms.size() - m, 13);
    chk("dr_tms", tms_seq(m, 13), 64'h1006);
    chk("dr_tdi", tdi_seq(m + 3, 8), 64'hA5);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("backpressure", {rsp_valid, cmd_ready, tck, rsp_data}, {3'b100, 64'h3C});
    end
    release_rsp("dr");
    chk("dr_tap_rti", ts, RTI);
    send(1, 5, 64'h11, m);
    sb.push_back(64'h01);
    wait_rsp("ir", 45);
    chk("ir_tms_prefix", tms_seq(m, 4), 64'hC);
    chk("ir_update", ir, 5'h11);
    release_rsp("ir");
    send(0, 0, 64'hFFFF, m);
    sb.push_back(64'h0);
    wait_rsp("rstcmd", 25);
    chk("rstcmd_tms", tms_seq(m, 6), 64'h3E);
    chk("rstcmd_ir_reset", ir, 5'h01);
    release_rsp("rstcmd");
    d = {$urandom, $urandom};
    send(0, 100, d, m);
    sb.push_back({d[55:0], DR_CAP});
    wait_rsp("clamp", 277);
    chk("clamp_tck_count", q_tms.size() - m, 69);
    release_rsp("clamp");
    // back-to-back with rsp_ready and cmd_valid held high
    rsp_ready = 1; cmd_valid = 1; cmd_ir = 0; cmd_len = 8; cmd_data = 64'h5A;
    sb.push_back(64'h3C);
    tick();
    chk("b2b_accept1", {busy, cmd_ready}, 2'b10);
    wait_rsp("b2b1", 53);
    n0 = n_rise;
    sb.push_back(64'h3C);
    tick();
    chk("b2b_idle", {rsp_valid, cmd_ready}, 2'b01);
    tick();
    chk("b2b_accept2", {busy, cmd_ready}, 2'b10);
    chk("b2b_no_tck", n_rise - n0, 0);
    cmd_valid = 0;
    wait_rsp("b2b2", 53);
    tick();
    chk("b2b_done", {rsp_valid, cmd_ready}, 2'b01);
    rsp_ready = 0;
    // abort a 32-bit DR scan at shift bit 3 (7th TCK rise)
    send(0, 32, 64'hDEADBEEF, m);
    k = 0;
    while (n_rise < m + 7 && k < 500) begin tick(); k++; end
    chk("abort_reach_bit3", n_rise - m, 7);
    rst = 1;
    tick();
    chk("abort_outputs", {tck, tms, rsp_valid, busy, cmd_ready}, 5'b01010);
    rst = 0;
    m = q_tms.size();
    k = 0;
    stale = 0;
    while (!cmd_ready && k < 200) begin tick(); k++; stale += int'(rsp_valid); end
    chk("abort_por_latency", k, 25);
    chk("abort_tms", tms_seq(m, 6), 64'h3E);
    chk("abort_tap_rti", ts, RTI);
    for (int i = 0; i < 100; i++) begin tick(); stale += int'(rsp_valid); end
    chk("abort_no_stale", stale, 0);
    chk("abort_rsp_data", rsp_data, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/jtag_tap_sequencer.md
Name: jtag_tap_sequencer

Overview:
- On-chip JTAG master that drives the debug TAP directly from the system clock domain.
- Accepts IR/DR scan and TAP-reset commands over a valid/ready interface and generates divided TCK, TMS and TDI.
- Captures TDO during each scan and returns the captured bits as a response.
- Lets firmware or a debug bridge exercise the RISC-V debug transport module without going through the BSCAN user-chain tunnel.

Parameters:
- DATA_W, 64: maximum scan length in bits; width of cmd_data and rsp_data.
- LEN_W, 7: width of cmd_len; must satisfy 2^LEN_W > DATA_W.
- CLK_DIV, 2: system clocks per TCK half-period; must be ≥ 1.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_ir  in  1  1 = IR scan, 0 = DR scan.
- cmd_len  in  LEN_W  scan length in bits; 0 = TAP reset command.
- cmd_data  in  DATA_W  TDI bits, LSB shifted first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DATA_W  captured TDO bits, LSB first; upper bits zero.
- busy  out  1  high in every state except IDLE.
- jtag_tck  out  1  generated TCK, registered.
- jtag_tms  out  1  TMS, registered.
- jtag_tdi  out  1  TDI, registered.
- jtag_tdo  in  1  TAP TDO, already synchronous to the sequencer.

Behaviour:
- Reset values: jtag_tck=0, jtag_tms=1, jtag_tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1. The state machine enters RST_SEQ.
- TCK generation:
  - Each TCK cycle is a low phase of CLK_DIV clocks followed by a high phase of CLK_DIV clocks.
  - TMS and TDI update only on the clock where jtag_tck goes 1→0, i.e. at the start of the low phase.
  - jtag_tdo is sampled on the clock where jtag_tck goes 0→1.
  - When no scan is in progress, jtag_tck is held at 0.
- States:
  - RST_SEQ: 5 TCK cycles with TMS=1, then 1 TCK cycle with TMS=0, leaving the TAP in Run-Test/Idle. Goes to IDLE.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch the command and go to RST_SEQ if the latched length is 0, otherwise to HDR. The first low phase begins on the next clock.
  - HDR: TMS sequence 1,0,0 for DR scans or 1,1,0,0 for IR scans, with TDI=0. Ends in Shift-xR. Goes to SHIFT.
  - SHIFT: L TCK cycles. Cycle i drives TDI=data[i], with TMS=0 for i<L-1 and TMS=1 for i=L-1 (to Exit1). TDO sampled at the rising edge of cycle i is written to rsp_data[i]. Goes to TRAIL.
  - TRAIL: TMS sequence 1,0 (Update, then Run-Test/Idle), with TDI=0. Goes to RSP.
  - RSP: rsp_valid=1 and rsp_data stable. On rsp_ready, go to IDLE.
- Length rules:
  - L = min(cmd_len, DATA_W).
  - rsp_data bits ≥ L read 0; rsp_data is cleared when a command is accepted.
  - A cmd_len=0 command runs the reset sequence and then returns a response with rsp_data=0.
- Scan size and latency:
  - TCK cycles per scan: N = 3+L+2 for DR, 4+L+2 for IR, and 6 for a reset command.
  - rsp_valid rises exactly 1 + 2·CLK_DIV·N clocks after the accept edge, on the same edge that the final high phase ends (TCK returns to 0).
- Boundary conditions:
  - cmd_ready is low in all states except IDLE. A command presented while busy is held off; no command is ever dropped.
  - cmd_valid and the RSP→IDLE transition in the same clock: the command is accepted only in the following cycle, when the state is IDLE.
  - rsp_ready may be held high permanently; RSP then lasts exactly one clock.
  - After power-on reset, cmd_ready first asserts 1 + 2·CLK_DIV·6 clocks after reset deasserts.
  - reset asserted mid-scan aborts the scan on that edge: outputs return to reset values, any pending response is discarded, and RST_SEQ reruns.
  - cmd_len > DATA_W is clamped to DATA_W; the extra length is never shifted.

Test Plan:
- Power-on with CLK_DIV=2: release reset → exactly 6 TCK rising edges with TMS values 1,1,1,1,1,0; cmd_ready rises 25 clocks after reset deasserts.
- DR scan, CLK_DIV=2, cmd_len=8, cmd_data=0xA5, TAP model with an 8-bit DR preloaded to 0x3C → TMS per TCK cycle = 1,0,0,0,0,0,0,0,0,0,1,1,0; TDI LSB-first reads 0xA5; rsp_data=0x3C; rsp_valid rises 53 clocks after accept.
- IR scan, cmd_len=5, cmd_data=0x11, TAP model capturing IR=0x01 → TMS prefix 1,1,0,0; rsp_data=0x01; TAP IR register=0x11 after Update.
- Back-to-back commands with rsp_ready held high and cmd_valid asserted continuously → the second command is accepted exactly 2 clocks after the first response's rsp_valid rises; no TCK edge occurs between scans.
- Backpressure: rsp_ready=0 for 20 clocks during RSP → rsp_valid and rsp_data stay stable, cmd_ready stays 0, jtag_tck stays 0.
- Abort: assert reset at SHIFT bit 3 of a 32-bit DR scan → next clock has tck=0, tms=1, rsp_valid=0; a full RST_SEQ follows; no stale response ever appears.
